qtwos_conv_pipe: RTL

- Streaming, parametrised Q-format sign/magnitude (SM) and two's-complement (TC) converter for the fixed-point math library.
- Four per-transaction modes:
  - SM->TC
  - TC->SM
  - SM negate
  - TC negate
- Input width N, output width W >= N; saturation and overflow flag where the target cannot represent the value.
- Two-stage registered pipeline with valid/ready on both sides and a pass-through tag; sits between the qmult/qdiv/qadd datapaths and TC consumers such as filters and DACs.

---
 rtl/qfmt_pkg.sv | 19 +
 rtl/qpipe_stage.sv | 29 ++
 rtl/qtwos_conv_pipe.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/qfmt_pkg.sv
// Shared constants and helpers for the fixed-point SM/TC conversion blocks.
package qfmt_pkg;

    // Per-transaction operation select
    localparam logic [1:0] QM_SM2TC = 2'b00;
    localparam logic [1:0] QM_TC2SM = 2'b01;
    localparam logic [1:0] QM_NEGSM = 2'b10;
    localparam logic [1:0] QM_NEGTC = 2'b11;

    // Widest word the helper below can inspect
    localparam int QF_MAXW = 128;

    // True when the low n bits of a hold the most negative n-bit TC value (10..0).
    // Callers zero-extend their word to QF_MAXW.
    function automatic logic is_most_neg(input logic [QF_MAXW-1:0] a, input int n);
        return a == (QF_MAXW'(1) << (n - 1));
    endfunction

endpackage

// File: rtl/qpipe_stage.sv
// Generic valid/ready register slice: loads whenever empty or drained downstream.
module qpipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          ready_out,
    output logic          en,
    output logic          valid,
    output logic [DW-1:0] data
);

    assign en = !valid || ready_out;

    // Capture the upstream word when the slot is free; hold it while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (en) begin
            valid <= in_valid;
            if (in_valid)
                data <= in_data;
        end
    end

endmodule

// File: rtl/qtwos_conv_pipe.sv
// Two-stage streaming sign/magnitude <-> two's-complement converter with
// saturation. S1 decodes into an operand plus carry-in; S2 adds, then packs
// and saturates. The binary point is never moved.
module qtwos_conv_pipe
    import qfmt_pkg::*;
#(
    parameter int Q     = 15,
    parameter int N     = 32,
    parameter int W     = 64,
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_mode,
    input  logic [N-1:0]     i_a,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [W-1:0]     o_b,
    output logic             o_ovf,
    output logic [TAG_W-1:0] o_tag
);

    localparam int WM1 = W - 1;
    localparam int S1W = 1 + W + 1 + 1 + 2 + TAG_W;
    localparam int S2W = W + 1 + TAG_W;

    if (W < N) begin : g_bad_width
        $error("qtwos_conv_pipe: W must be >= N");
    end
    if (N > QF_MAXW || W > QF_MAXW) begin : g_bad_max
        $error("qtwos_conv_pipe: width exceeds QF_MAXW");
    end
    if (Q >= N) begin : g_bad_q
        $error("qtwos_conv_pipe: Q must leave room for the sign bit");
    end

    // ---------------- S1 decode ----------------
    logic           s_in;
    logic [W-1:0]   ax;      // TC operand sign-extended
    logic [W-1:0]   mx;      // SM magnitude zero-extended
    logic           min_w;   // most-negative input that W cannot negate
    logic           d_sign, d_inc, d_sat;
    logic [W-1:0]   d_opnd;

    assign s_in  = i_a[N-1];
    assign ax    = W'($signed(i_a));
    assign mx    = W'(i_a[N-2:0]);
    assign min_w = (W == N) && is_most_neg(QF_MAXW'(i_a), N);

    // Negation is split as invert-now, add-carry-next-stage
    always_comb begin
        d_sign = s_in;
        d_opnd = ax;
        d_inc  = 1'b0;
        d_sat  = 1'b0;
        case (i_mode)
            QM_SM2TC: begin
                d_opnd = s_in ? ~mx : mx;
                d_inc  = s_in;
            end
            QM_TC2SM: begin
                d_opnd = s_in ? ~ax : ax;
                d_inc  = s_in;
                d_sat  = min_w;
            end
            QM_NEGSM: begin
                d_sign = ~s_in;
                d_opnd = mx;
            end
            default: begin
                d_opnd = ~ax;
                d_inc  = 1'b1;
                d_sat  = min_w;
            end
        endcase
    end

    logic           s1_en, s1_valid, s2_en, s2_valid;
    logic [S1W-1:0] s1_data;
    logic [S2W-1:0] s2_data;

    qpipe_stage #(.DW(S1W)) u_s1 (
        .clk       (i_clk),
        .rst       (i_rst),
        .in_valid  (i_valid),
        .in_data   ({d_sign, d_opnd, d_inc, d_sat, i_mode, i_tag}),
        .ready_out (s2_en),
        .en        (s1_en),
        .valid     (s1_valid),
        .data      (s1_data)
    );

    assign o_ready = s1_en;

    // ---------------- S2 add / pack / saturate ----------------
    logic             r_sign, r_inc, r_sat;
    logic [W-1:0]     r_opnd, sum, r_b;
    logic [1:0]       r_mode;
    logic [TAG_W-1:0] r_tag;
    logic             r_ovf;

    assign {r_sign, r_opnd, r_inc, r_sat, r_mode, r_tag} = s1_data;
    assign sum = r_opnd + W'(r_inc);

    // Final result selection; sat only ever arises for TC2SM/NEGTC at W==N
    always_comb begin
        r_b   = sum;
        r_ovf = 1'b0;
        case (r_mode)
            QM_SM2TC: r_b = sum;
            QM_TC2SM: begin
                r_b   = r_sat ? '1 : {r_sign, sum[W-2:0]};
                r_ovf = r_sat;
            end
            QM_NEGSM: r_b = (r_opnd[W-2:0] == '0) ? '0 : {r_sign, r_opnd[W-2:0]};
            default: begin
                r_b   = r_sat ? {1'b0, {WM1{1'b1}}} : sum;
                r_ovf = r_sat;
            end
        endcase
    end

    qpipe_stage #(.DW(S2W)) u_s2 (
        .clk       (i_clk),
        .rst       (i_rst),
        .in_valid  (s1_valid),
        .in_data   ({r_b, r_ovf, r_tag}),
        .ready_out (i_ready),
        .en        (s2_en),
        .valid     (s2_valid),
        .data      (s2_data)
    );

    assign o_valid               = s2_valid;
    assign {o_b, o_ovf, o_tag}   = s2_data;

endmodule
